// File: rtl/shift_add_multiplier.sv
// ============================================================================
// Module   : shift_add_multiplier
// Function : Sequential shift-and-add multiplier (unsigned or two's-complement),
//            product left in {A,B}, with Busy/Done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             Signed_Mode,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Xval,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_clear = 3'd1;
  localparam logic [2:0] c_add   = 3'd2;
  localparam logic [2:0] c_shift = 3'd3;
  localparam logic [2:0] c_hold  = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_x;
  logic             r_mode;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_s_ext;
  logic [WIDTH:0]   w_sum;

  always_comb begin
    w_next_state = c_idle;
    case (r_state)
      c_idle:  w_next_state = Run ? c_clear : c_idle;
      c_clear: w_next_state = c_add;
      c_add:   w_next_state = c_shift;
      c_shift: w_next_state = (r_count == c_last) ? c_hold : c_add;
      c_hold:  w_next_state = Run ? c_hold : c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // The multiplier's top bit carries negative weight in signed mode, so the
  // last partial product is subtracted rather than added.
  always_comb begin
    w_a_ext = {r_a[WIDTH-1] & r_mode, r_a};
    w_s_ext = {r_s[WIDTH-1] & r_mode, r_s};
    if (r_mode && (r_count == c_last))
      w_sum = w_a_ext - w_s_ext;
    else
      w_sum = w_a_ext + w_s_ext;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= c_idle;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_x     <= 1'b0;
      r_mode  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        c_idle: begin
          if (ClearA_LoadB) begin
            r_a <= '0;
            r_x <= 1'b0;
            r_b <= Din;
          end
        end
        c_clear: begin
          r_a     <= '0;
          r_x     <= 1'b0;
          r_s     <= Din;
          r_mode  <= Signed_Mode;
          r_count <= '0;
        end
        c_add: begin
          if (r_b[0])
            {r_x, r_a} <= w_sum;
        end
        c_shift: begin
          r_a <= {r_x, r_a[WIDTH-1:1]};
          r_b <= {r_a[0], r_b[WIDTH-1:1]};
          // In unsigned mode X is a one-shot carry, consumed by this shift.
          if (!r_mode)
            r_x <= 1'b0;
          if (r_count != c_last)
            r_count <= r_count + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign Aval = r_a;
  assign Bval = r_b;
  assign Xval = r_x;
  assign Busy = (r_state == c_clear) || (r_state == c_add) || (r_state == c_shift);
  assign Done = (r_state == c_hold);

endmodule

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// ============================================================================
// Module   : tb_shift_add_multiplier
// Function : Directed and random checks of shift_add_multiplier at WIDTH 8 and 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_multiplier;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       run8 = 1'b0, load8 = 1'b0, sm8 = 1'b0;
  logic [7:0] din8 = 8'h00;
  logic [7:0] a8, b8;
  logic       x8, busy8, done8;
  logic       run4 = 1'b0, load4 = 1'b0, sm4 = 1'b0;
  logic [3:0] din4 = 4'h0;
  logic [3:0] a4, b4;
  logic       x4, busy4, done4;

  int total = 0;
  int bad   = 0;
  logic [7:0] mb8 = 8'h00;
  logic [7:0] mb4 = 8'h00;

  always #5 Clk = ~Clk;

  shift_add_multiplier #(.WIDTH(8)) u_dut8 (
    .Clk(Clk), .Reset(Reset), .Run(run8), .ClearA_LoadB(load8), .Signed_Mode(sm8),
    .Din(din8), .Aval(a8), .Bval(b8), .Xval(x8), .Busy(busy8), .Done(done8)
  );

  shift_add_multiplier #(.WIDTH(4)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .Run(run4), .ClearA_LoadB(load4), .Signed_Mode(sm4),
    .Din(din4), .Aval(a4), .Bval(b4), .Xval(x4), .Busy(busy4), .Done(done4)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer product of the operands interpreted per mode.
  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] b,
                                          input logic [7:0] s, input bit sm);
    int bb, ss, p;
    bb = int'(b) & ((1 << w) - 1);
    ss = int'(s) & ((1 << w) - 1);
    if (sm && b[w-1]) bb = bb - (1 << w);
    if (sm && s[w-1]) ss = ss - (1 << w);
    p = bb * ss;
    return 16'(p & ((1 << (2 * w)) - 1));
  endfunction

  task automatic drive(input int w, input bit r, input bit l, input bit m, input logic [7:0] d);
    if (w == 8) begin
      run8 = r; load8 = l; sm8 = m; din8 = d;
    end else begin
      run4 = r; load4 = l; sm4 = m; din4 = d[3:0];
    end
  endtask

  function automatic logic [15:0] prod(input int w);
    return (w == 8) ? {a8, b8} : {8'h00, a4, b4};
  endfunction
  function automatic logic get_x(input int w);    return (w == 8) ? x8 : x4;       endfunction
  function automatic logic get_busy(input int w); return (w == 8) ? busy8 : busy4; endfunction
  function automatic logic get_done(input int w); return (w == 8) ? done8 : done4; endfunction

  task automatic mult(input int w, input bit do_load, input bit same, input logic [7:0] b,
                      input logic [7:0] s, input bit sm, input int hold, input string tag);
    logic [7:0]  bv, d;
    logic [15:0] exp;
    bit          m;
    int          cyc, bcnt, bh, dlow;
    bv  = do_load ? b : ((w == 8) ? mb8 : mb4);
    exp = ref_mul(w, bv, s, sm);
    if (do_load && !same) begin
      drive(w, 1'b0, 1'b1, sm, b);
      tick();
    end
    drive(w, 1'b1, do_load && same, sm, same ? b : s);
    tick();
    m = sm; d = s;
    drive(w, 1'b1, 1'b0, m, d);
    cyc = 0; bcnt = 0;
    while (!get_done(w) && cyc < 100) begin
      if (get_busy(w)) bcnt++;
      if (cyc >= 1) begin
        d = 8'($urandom);
        m = 1'($urandom);
      end
      drive(w, 1'b1, cyc == 5, m, d);
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(2 * w + 1));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(2 * w + 1));
    chk({tag, "_product"}, 32'(prod(w)), 32'(exp));
    if (!sm) chk({tag, "_x"}, 32'(get_x(w)), 32'd0);
    bh = 0; dlow = 0;
    for (int i = 0; i < hold; i++) begin
      if (get_busy(w)) bh++;
      if (!get_done(w)) dlow++;
      drive(w, 1'b1, i == 2, 1'($urandom), 8'($urandom));
      tick();
    end
    if (hold > 0) begin
      chk({tag, "_hold_busy"}, 32'(bh), 32'd0);
      chk({tag, "_hold_done_low"}, 32'(dlow), 32'd0);
      chk({tag, "_hold_product"}, 32'(prod(w)), 32'(exp));
    end
    drive(w, 1'b0, 1'b0, m, d);
    tick();
    chk({tag, "_idle_done"}, 32'(get_done(w)), 32'd0);
    chk({tag, "_idle_busy"}, 32'(get_busy(w)), 32'd0);
    chk({tag, "_idle_product"}, 32'(prod(w)), 32'(exp));
    if (w == 8) mb8 = exp[7:0];
    else        mb4 = {4'h0, exp[3:0]};
  endtask

  initial begin
    Reset = 1'b1;
    tick();
    tick();
    chk("rst_prod8", 32'(prod(8)), 32'd0);
    chk("rst_flags8", {29'd0, x8, busy8, done8}, 32'd0);
    chk("rst_prod4", 32'(prod(4)), 32'd0);
    chk("rst_flags4", {29'd0, x4, busy4, done4}, 32'd0);
    Reset = 1'b0;
    tick();

    mult(8, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 0, "u_ff_ff");
    mult(8, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 0, "s_ff_ff");
    mult(8, 1'b1, 1'b0, 8'hF9, 8'h07, 1'b1, 0, "s_f9_07");
    mult(8, 1'b1, 1'b0, 8'h7F, 8'h80, 1'b1, 0, "s_7f_80");
    mult(8, 1'b1, 1'b0, 8'h80, 8'h80, 1'b1, 0, "s_80_80");

    // Run held high well past Done, then a second run on the retained B.
    mult(8, 1'b1, 1'b0, 8'h03, 8'h05, 1'b0, 23, "hs_first");
    mult(8, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 0, "hs_second");

    // Reset in the sixth Busy cycle.
    drive(8, 1'b0, 1'b1, 1'b0, 8'h5A);
    tick();
    drive(8, 1'b1, 1'b0, 1'b0, 8'h33);
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("pre_reset_busy", 32'(busy8), 32'd1);
    Reset = 1'b1;
    drive(8, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("midrst_prod", 32'(prod(8)), 32'd0);
    chk("midrst_flags", {29'd0, x8, busy8, done8}, 32'd0);
    Reset = 1'b0;
    mb8 = 8'h00;
    mb4 = 8'h00;
    tick();
    mult(8, 1'b1, 1'b0, 8'hC3, 8'h5D, 1'b1, 0, "after_rst");

    mult(8, 1'b1, 1'b1, 8'h0B, 8'hF3, 1'b1, 0, "load_run_same");

    mult(4, 1'b1, 1'b0, 8'h0F, 8'h0F, 1'b0, 0, "w4_u_f_f");
    mult(4, 1'b1, 1'b0, 8'h08, 8'h08, 1'b1, 0, "w4_s_8_8");

    for (int i = 0; i < 1000; i++)
      mult(4, ($urandom % 4) != 0, 1'($urandom), 8'($urandom), 8'($urandom), 1'(i), 0, "rnd4");
    for (int i = 0; i < 150; i++)
      mult(8, ($urandom % 4) != 0, 1'($urandom), 8'($urandom), 8'($urandom), 1'(i), 0, "rnd8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
